dm_access_seq: RTL and testbench

- Sequential data-memory access controller between the execute stage and the synchronous data memory.
- Executes one load or store per request over a handshake. Sub-word stores (byte/half) are done as read-modify-write: read the aligned word, merge the new lane(s), write the word back.
- Loads are extracted and sign/zero-extended from the aligned word.
- Sole writer of the data memory.

---
 rtl/dm_access_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_dm_access_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_seq.sv
// Sequential load/store controller between execute and a synchronous data memory; sub-word stores use read-modify-write.
// Optional build macro RMW_LAST_WORD_EN adds a one-entry last-written-word register that bypasses the memory read on a hit.
module dm_access_seq #(
    parameter int AW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sgn,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   busb,
    input  logic [31:0]   dm_out,
    output logic          busy,
    output logic          done,
    output logic          misalign,
    output logic [31:0]   rdata,
    output logic          dm_re,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_in
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [2:0]    wait_cnt_r;
    logic [2:0]    wait_cnt_nxt_s;
    logic          capture_s;
    logic          we_r;
    logic [1:0]    size_r;
    logic          sgn_r;
    logic [1:0]    lane_r;
    logic [31:0]   busb_r;
    logic [31:0]   rdata_nxt_s;
    logic [31:0]   dm_in_nxt_s;
    logic [AW-1:0] dm_addr_nxt_s;
    logic          busy_r;
    logic          done_r;
    logic          misalign_r;
    logic          dm_re_r;
    logic          dm_we_r;
    logic [31:0]   rdata_r;
    logic [31:0]   dm_in_r;
    logic [AW-1:0] dm_addr_r;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
        logic r;
        case (sz)
            2'b00:   r = 1'b0;
            2'b01:   r = lane[0];
            2'b10:   r = (lane != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] lane, input logic [1:0] sz);
        logic [31:0] r;
        case (sz)
            2'b00: begin
                case (lane)
                    2'd0:    r = {word[31:8], data[7:0]};
                    2'd1:    r = {word[31:16], data[7:0], word[7:0]};
                    2'd2:    r = {word[31:24], data[7:0], word[15:0]};
                    default: r = {data[7:0], word[23:0]};
                endcase
            end
            2'b01:   r = lane[1] ? {data[15:0], word[15:0]} : {word[31:16], data[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

`ifdef RMW_LAST_WORD_EN
    logic [31:0]   last_word_r;
    logic [AW-3:0] last_addr_r;
    logic          last_vld_r;
    logic          hit_s;

    assign hit_s = last_vld_r && (last_addr_r == addr[AW-1:2]);

    // Last-written-word register, refreshed by every memory write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_word_r <= 32'h0000_0000;
            last_addr_r <= '0;
            last_vld_r  <= 1'b0;
        end else if (state_r == ST_WRITE) begin
            last_word_r <= dm_in_r;
            last_addr_r <= dm_addr_r[AW-1:2];
            last_vld_r  <= 1'b1;
        end else begin
            last_vld_r  <= last_vld_r;
        end
    end
`endif

    // State and wait-counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        capture_s      = 1'b0;
        rdata_nxt_s    = rdata_r;
        dm_in_nxt_s    = dm_in_r;
        dm_addr_nxt_s  = dm_addr_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    capture_s     = 1'b1;
                    dm_addr_nxt_s = {addr[AW-1:2], 2'b00};
                    if (is_misaligned(size, addr[1:0])) begin
                        state_nxt_s = ST_ERR;
                    end else if (we && (size == 2'b10)) begin
                        dm_in_nxt_s = busb;
                        state_nxt_s = ST_WRITE;
                    end else begin
`ifdef RMW_LAST_WORD_EN
                        if (hit_s && we) begin
                            dm_in_nxt_s = merge_store(last_word_r, busb, addr[1:0], size);
                            state_nxt_s = ST_WRITE;
                        end else if (hit_s) begin
                            rdata_nxt_s = extract_load(last_word_r, addr[1:0], size, sgn);
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_READ;
                        end
`else
                        state_nxt_s = ST_READ;
`endif
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                wait_cnt_nxt_s = 3'd0;
                state_nxt_s    = ST_WAIT;
            end
            ST_WAIT: begin
                // dm_out is valid on the last of the RD_LAT wait cycles
                if (wait_cnt_r == LAST_CNT) begin
                    if (we_r) begin
                        dm_in_nxt_s = merge_store(dm_out, busb_r, lane_r, size_r);
                        state_nxt_s = ST_WRITE;
                    end else begin
                        rdata_nxt_s = extract_load(dm_out, lane_r, size_r, sgn_r);
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 3'd1;
                end
            end
            ST_WRITE: state_nxt_s = ST_DONE;
            ST_DONE:  state_nxt_s = ST_IDLE;
            ST_ERR:   state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r   <= 1'b0;
            size_r <= 2'b00;
            sgn_r  <= 1'b0;
            lane_r <= 2'b00;
            busb_r <= 32'h0000_0000;
        end else if (capture_s) begin
            we_r   <= we;
            size_r <= size;
            sgn_r  <= sgn;
            lane_r <= addr[1:0];
            busb_r <= busb;
        end else begin
            we_r   <= we_r;
        end
    end

    // Registered outputs, aligned with the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            misalign_r <= 1'b0;
            dm_re_r    <= 1'b0;
            dm_we_r    <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            dm_in_r    <= 32'h0000_0000;
            dm_addr_r  <= '0;
        end else begin
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= (state_nxt_s == ST_DONE) || (state_nxt_s == ST_ERR);
            misalign_r <= (state_nxt_s == ST_ERR);
            dm_re_r    <= (state_nxt_s == ST_READ);
            dm_we_r    <= (state_nxt_s == ST_WRITE);
            rdata_r    <= rdata_nxt_s;
            dm_in_r    <= dm_in_nxt_s;
            dm_addr_r  <= dm_addr_nxt_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign misalign = misalign_r;
    assign dm_re    = dm_re_r;
    assign dm_we    = dm_we_r;
    assign rdata    = rdata_r;
    assign dm_in    = dm_in_r;
    assign dm_addr  = dm_addr_r;

endmodule

// File: tb/tb_dm_access_seq.sv
// Scoreboard bench for dm_access_seq: a reference memory model predicts each completion and write; a forked monitor checks them.
module tb_dm_access_seq;

    localparam int AW     = 10;
    localparam int RD_LAT = 1;
    localparam int NW     = 1 << (AW - 2);
`ifdef RMW_LAST_WORD_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    typedef struct {
        bit          mis;
        int          lat;
        int          nre;
        int          nwe;
        logic [31:0] rd;
        int          t_acc;
    } exp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          sgn;
    logic [AW-1:0] addr;
    logic [31:0]   busb;
    logic [31:0]   dm_out;
    logic          busy;
    logic          done;
    logic          misalign;
    logic [31:0]   rdata;
    logic          dm_re;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_in;

    logic [31:0] mem     [NW];
    logic [31:0] ref_mem [NW];
    logic [31:0] rd_pipe [RD_LAT];
    logic        preload;
    int          cyc = 0;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    wr_t         wq[$];
    logic [31:0] rd_model = 32'h0;
    bit          lw_valid = 1'b0;
    int          lw_word  = 0;

    dm_access_seq #(.AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sgn(sgn),
        .addr(addr), .busb(busb), .dm_out(dm_out), .busy(busy), .done(done),
        .misalign(misalign), .rdata(rdata), .dm_re(dm_re), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_in(dm_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous data memory with RD_LAT read pipeline
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NW; i++) mem[i] <= ref_mem[i];
        end else if (dm_we) begin
            mem[dm_addr[AW-1:2]] <= dm_in;
        end
        if (dm_re) rd_pipe[0] <= mem[dm_addr[AW-1:2]];
        else       rd_pipe[0] <= 32'hDEAD_0BAD;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign dm_out = rd_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        wr_t  w;
        int   re_cnt = 0;
        int   we_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                re_cnt = 0;
                we_cnt = 0;
            end else begin
                if (dm_re) re_cnt++;
                if (dm_we) begin
                    we_cnt++;
                    if (wq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, expected no write", dm_addr, dm_in);
                    end else begin
                        w = wq.pop_front();
                        chk("wr_addr", 32'(dm_addr), 32'(w.a));
                        chk("wr_data", dm_in, w.d);
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("misalign", 32'(misalign), 32'(e.mis));
                        chk("latency", 32'(cyc - e.t_acc), 32'(e.lat));
                        chk("dm_re_count", 32'(re_cnt), 32'(e.nre));
                        chk("dm_we_count", 32'(we_cnt), 32'(e.nwe));
                        chk("rdata", rdata, e.rd);
                    end
                    re_cnt = 0;
                    we_cnt = 0;
                end
            end
        end
    endtask

    // Drive one request and push the reference model's predicted response
    task automatic issue(input bit w, input logic [1:0] sz, input bit sg,
                         input logic [AW-1:0] a, input logic [31:0] d);
        logic [31:0] old, nv, msk, v;
        int   wi, sh, guard;
        bit   mis, hit;
        exp_t e;
        wr_t  wr;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_before_req", 32'(busy), 32'h0);
        wi  = int'(a[AW-1:2]);
        old = ref_mem[wi];
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        hit = RMW_EN && lw_valid && (lw_word == wi);
        sh  = (sz == 2'b00) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        msk = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        msk = msk << sh;
        e.mis = mis;
        e.nre = 0;
        e.nwe = 0;
        if (mis) begin
            e.lat = 1;
        end else if (w) begin
            if (sz == 2'b10) begin
                nv    = d;
                e.lat = 2;
            end else begin
                nv    = (old & ~msk) | ((d << sh) & msk);
                e.lat = hit ? 2 : 3 + RD_LAT;
                e.nre = hit ? 0 : 1;
            end
            e.nwe       = 1;
            ref_mem[wi] = nv;
            wr.a        = AW'(wi * 4);
            wr.d        = nv;
            wq.push_back(wr);
            lw_valid    = 1'b1;
            lw_word     = wi;
        end else begin
            if (sz == 2'b10) begin
                v = old;
            end else begin
                v = (old & msk) >> sh;
                if (sg && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
                if (sg && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
            end
            rd_model = v;
            e.lat    = hit ? 1 : 2 + RD_LAT;
            e.nre    = hit ? 0 : 1;
        end
        e.rd    = rd_model;
        e.t_acc = cyc;
        exp_q.push_back(e);
        req = 1'b1; we = w; size = sz; sgn = sg; addr = a; busb = d;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("pending_completions", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        logic [31:0]   saved;
        logic [AW-1:0] ra;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sgn = 1'b0;
        addr = '0; busb = 32'h0; preload = 1'b1;
        for (int i = 0; i < NW; i++) ref_mem[i] = $urandom();
        ref_mem[8]  = 32'h1122_3344;
        ref_mem[12] = 32'h8000_F0FF;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        preload = 1'b0;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk("rst_dm_re", 32'(dm_re), 32'h0);
        chk("rst_dm_we", 32'(dm_we), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_dm_in", dm_in, 32'h0);
        chk("rst_dm_addr", 32'(dm_addr), 32'h0);
        rst_n = 1'b1;

        issue(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEAD_BEEF); wait_idle();
        issue(1'b1, 2'b00, 1'b0, 10'h022, 32'h0000_00AA); wait_idle();
        chk("sb_merge_word", ref_mem[8], 32'h11AA_3344);
        issue(1'b0, 2'b00, 1'b1, 10'h030, 32'h0);         wait_idle();
        chk("lb_sext", rd_model, 32'hFFFF_FFFF);
        issue(1'b0, 2'b00, 1'b0, 10'h031, 32'h0);         wait_idle();
        chk("lbu_zext", rd_model, 32'h0000_00F0);
        issue(1'b0, 2'b01, 1'b1, 10'h032, 32'h0);         wait_idle();
        chk("lh_sext", rd_model, 32'hFFFF_8000);
        issue(1'b1, 2'b01, 1'b0, 10'h041, 32'h1234_5678); wait_idle();

        // Abort a sub-word store in WAIT with reset
        saved = ref_mem[24];
        issue(1'b1, 2'b00, 1'b0, 10'h062, 32'h0000_00C3);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_dm_we", 32'(dm_we), 32'h0);
        chk("abort_dm_re", 32'(dm_re), 32'h0);
        exp_q.delete();
        wq.delete();
        ref_mem[24] = saved;
        rd_model    = 32'h0;
        lw_valid    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("abort_word_kept", mem[24], saved);
        issue(1'b0, 2'b10, 1'b0, 10'h060, 32'h0); wait_idle();

        issue(1'b1, 2'b10, 1'b0, 10'h050, 32'h0102_0304); wait_idle();
        issue(1'b1, 2'b00, 1'b0, 10'h053, 32'h0000_0099); wait_idle();
        chk("sb_after_sw", ref_mem[20], 32'h9902_0304);

        for (int n = 0; n < 120; n++) begin
            ra = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, $urandom());
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                req = 1'b1; we = 1'b1; size = 2'b10; addr = 10'h3FC; busb = 32'hBAD0_BAD0;
                @(negedge clk);
                req = 1'b0;
            end
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("writes_drained", 32'(wq.size()), 32'h0);
        for (int i = 0; i < NW; i++) chk("mem_word", mem[i], ref_mem[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
